maze_bram_arbiter: RTL and testbench
====================================

// Module: maze_bram_arbiter
// PURPOSE
//   Shares the single-port 256x9 maze cell BRAM between NUM_REQ movers: player, enemies, collectible spawner.
//   Each requester posts one read or write with a req/ack handshake.
//   The block arbitrates round-robin, sequences the BRAM port, and returns read data.
//   Sits between the mover FSMs and the maze BRAM port, in the mvmt_clk domain.
// PARAMETERS
//   NUM_REQ   4  number of requesters; index 0 = player
//   ADDR_W    8  cell address width, addr = y*MAZE_SIZE + x
//   DATA_W    9  cell word: bit0 wall, [3:1] collectible type, [8:4] reserved
//   BRAM_LAT  1  BRAM read latency in mvmt_clk cycles (1..3)
// PORTS
//   mvmt_clk   in   1                movement clock
//   reset      in   1                asynchronous, active-high
//   en         in   1                game-running enable
//   req        in   NUM_REQ          per-requester request level
//   req_we     in   NUM_REQ          1 = write, 0 = read
//   req_addr   in   NUM_REQ*ADDR_W   packed addresses, requester i at [i*ADDR_W +: ADDR_W]
//   req_din    in   NUM_REQ*DATA_W   packed write data
//   gnt        out  NUM_REQ          one-hot current owner
//   ack        out  NUM_REQ          one-cycle completion pulse to owner
//   rdata      out  DATA_W           read data, valid while ack is high
//   bram_en    out  1                BRAM port enable
//   bram_we    out  1                BRAM write enable
//   bram_addr  out  ADDR_W           BRAM address
//   bram_din   out  DATA_W           BRAM write data
//   bram_dout  in   DATA_W           BRAM read data
//   busy       out  1                high in any state other than IDLE
// BEHAVIOUR
//   Reset (async): outputs all-zero, FSM=IDLE, rr_ptr=0.
//   FSM: IDLE -> ACCESS -> WAIT(BRAM_LAT cycles) -> DONE -> IDLE. All outputs registered.
//   IDLE
//     - If en and |req: pick winner w = first set req bit at or after rr_ptr, wrapping mod NUM_REQ.
//     - Latch req_we[w], req_addr[w], req_din[w].
//     - gnt <= 1<<w; go to ACCESS.
//   ACCESS
//     - bram_en=1, bram_we=latched we, bram_addr/bram_din driven for exactly 1 cycle.
//     - Go to WAIT.
//   WAIT
//     - Count BRAM_LAT cycles with bram_en=0.
//     - On the last cycle, rdata <= bram_dout for reads; rdata is unchanged for writes.
//   DONE
//     - ack[w]=1 for 1 cycle; rr_ptr <= (w+1) mod NUM_REQ.
//     - gnt clears on exit to IDLE.
//   Latency: req sampled at edge k -> ack high after edge k+3+BRAM_LAT-1; 4 cycles at BRAM_LAT=1.
//   Throughput: one transaction per 3+BRAM_LAT cycles.
//   Writes also ack; requester drops req on ack, otherwise it is re-arbitrated as a new transaction.
//   Only IDLE samples req; requester inputs are ignored while busy.
//   Arbitration boundaries:
//     - Simultaneous requests: round-robin; no requester waits more than NUM_REQ-1 transactions.
//     - req deasserted mid-transaction: transaction still completes and ack still pulses.
//     - en low: no new grant; an in-flight transaction completes normally.
//   Data-ordering boundaries:
//     - Write then read of the same address by different requesters: serialised; the read returns new data.
//     - Out-of-range addresses cannot occur (ADDR_W fills the 16x16 maze); no checking.
//   Reset mid-transaction: FSM->IDLE immediately; the BRAM write is dropped if reset lands before the ACCESS edge.
// STRUCTURE
//   maze_pkg (shared): MAZE_SIZE=16, CELL_WALL_BIT=0, CELL_COLL_LSB=1, CELL_COLL_MSB=3, collectible type codes.
//   Sub-module rr_priority_picker:
//     - Purely combinational; inputs req, rr_ptr.
//     - Outputs one-hot winner and its index.
//     - Reused by the enemy scheduler.
// TESTING
//   1. Single read: req[0]=1, addr=0x23, BRAM[0x23]=9'h005 -> gnt=0001, bram_en 1 cycle, ack[0] 4 cycles later, rdata=9'h005.
//   2. Write then read: req[1] write addr 0x23 din 9'h001, then req[2] read 0x23 -> ack[1], then ack[2] with rdata=9'h001.
//   3. All 4 req held 8 transactions: grant order 0,1,2,3,0,1,2,3; no grant twice before others.
//   4. en=0 with req[3]=1 -> gnt stays 0; en=0 during WAIT -> that ack[w] still pulses.
//   5. reset during WAIT -> gnt=0, ack=0, busy=0, rr_ptr=0 the same cycle; next req[2] granted normally.
//   6. BRAM_LAT=3 build: read latency = 6 cycles; rdata matches the memory model on every ack.

Source files
------------

// File: rtl/maze_bram_arbiter_pkg.sv
// rtl/maze_bram_arbiter_pkg.sv - maze cell layout, arbiter FSM states and shared helpers
package maze_bram_arbiter_pkg;

  localparam int MAZE_SIZE     = 16;
  localparam int CELL_ADDR_W   = 8;
  localparam int CELL_WALL_BIT = 0;
  localparam int CELL_COLL_LSB = 1;
  localparam int CELL_COLL_MSB = 3;

  typedef enum logic [2:0] {
    COLL_NONE  = 3'd0,
    COLL_COIN  = 3'd1,
    COLL_GEM   = 3'd2,
    COLL_HEART = 3'd3,
    COLL_KEY   = 3'd4
  } coll_type_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACCESS,
    ST_WAIT,
    ST_DONE
  } arb_state_t;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic logic [CELL_ADDR_W-1:0] cell_addr(input logic [3:0] x, input logic [3:0] y);
    return CELL_ADDR_W'(int'(y) * MAZE_SIZE + int'(x));
  endfunction

endpackage

// File: rtl/maze_bram_arbiter_if.sv
// rtl/maze_bram_arbiter_if.sv - requester-side req/ack bus shared by all maze movers
interface maze_bram_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 9
);

  logic [NUM_REQ-1:0]        req;
  logic [NUM_REQ-1:0]        req_we;
  logic [NUM_REQ*ADDR_W-1:0] req_addr;
  logic [NUM_REQ*DATA_W-1:0] req_din;
  logic [NUM_REQ-1:0]        gnt;
  logic [NUM_REQ-1:0]        ack;
  logic [DATA_W-1:0]         rdata;

  modport master (
    output req, req_we, req_addr, req_din,
    input  gnt, ack, rdata
  );

  modport slave (
    input  req, req_we, req_addr, req_din,
    output gnt, ack, rdata
  );

endinterface

// File: rtl/maze_bram_arbiter_rr_priority_picker.sv
// rtl/maze_bram_arbiter_rr_priority_picker.sv - combinational round-robin winner select
// First set request at or after the pointer wins, wrapping modulo NUM_REQ.
module rr_priority_picker #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = 2
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [IDX_W-1:0]   i_rr_ptr,
  output logic [NUM_REQ-1:0] o_onehot,
  output logic [IDX_W-1:0]   o_idx,
  output logic               o_valid
);

  logic [IDX_W:0] w_cand;

  // Scan from the farthest offset down so the nearest candidate overwrites last.
  always_comb begin
    o_onehot = '0;
    o_idx    = '0;
    o_valid  = |i_req;
    w_cand   = '0;
    for (int off = NUM_REQ - 1; off >= 0; off--) begin
      w_cand = {1'b0, i_rr_ptr} + (IDX_W + 1)'(off);
      if (w_cand >= (IDX_W + 1)'(NUM_REQ)) begin
        w_cand = w_cand - (IDX_W + 1)'(NUM_REQ);
      end
      if (i_req[w_cand[IDX_W-1:0]]) begin
        o_idx                      = w_cand[IDX_W-1:0];
        o_onehot                   = '0;
        o_onehot[w_cand[IDX_W-1:0]] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/maze_bram_arbiter.sv
// rtl/maze_bram_arbiter.sv - round-robin sharing of the single-port maze cell BRAM
// One transaction at a time: IDLE -> ACCESS -> WAIT x BRAM_LAT -> DONE, all outputs registered.
module maze_bram_arbiter
  import maze_bram_arbiter_pkg::*;
#(
  parameter int NUM_REQ  = 4,
  parameter int ADDR_W   = 8,
  parameter int DATA_W   = 9,
  parameter int BRAM_LAT = 1
) (
  input  logic              mvmt_clk,
  input  logic              reset,
  input  logic              i_en,
  maze_bram_arbiter_if.slave s_req,
  output logic              o_bram_en,
  output logic              o_bram_we,
  output logic [ADDR_W-1:0] o_bram_addr,
  output logic [DATA_W-1:0] o_bram_din,
  input  logic [DATA_W-1:0] i_bram_dout,
  output logic              o_busy
);

  localparam int         IDX_W     = idx_width(NUM_REQ);
  localparam logic [1:0] LAST_WAIT = 2'(BRAM_LAT - 1);

  arb_state_t          r_state;
  logic [IDX_W-1:0]    r_rr_ptr;
  logic [IDX_W-1:0]    r_owner;
  logic                r_we;
  logic [1:0]          r_wait_cnt;
  logic [NUM_REQ-1:0]  r_gnt;
  logic [NUM_REQ-1:0]  r_ack;
  logic [DATA_W-1:0]   r_rdata;
  logic                r_bram_en;
  logic                r_bram_we;
  logic [ADDR_W-1:0]   r_bram_addr;
  logic [DATA_W-1:0]   r_bram_din;
  logic                r_busy;

  logic [NUM_REQ-1:0]  w_pick_onehot;
  logic [IDX_W-1:0]    w_pick_idx;
  logic                w_pick_valid;
  logic                w_sel_we;
  logic [ADDR_W-1:0]   w_sel_addr;
  logic [DATA_W-1:0]   w_sel_din;
  logic [IDX_W-1:0]    w_next_ptr;

  rr_priority_picker #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_picker (
    .i_req    (s_req.req),
    .i_rr_ptr (r_rr_ptr),
    .o_onehot (w_pick_onehot),
    .o_idx    (w_pick_idx),
    .o_valid  (w_pick_valid)
  );

  always_comb begin
    w_sel_we   = 1'b0;
    w_sel_addr = '0;
    w_sel_din  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_pick_idx == IDX_W'(i)) begin
        w_sel_we   = s_req.req_we[i];
        w_sel_addr = s_req.req_addr[i*ADDR_W +: ADDR_W];
        w_sel_din  = s_req.req_din[i*DATA_W +: DATA_W];
      end
    end
  end

  assign w_next_ptr = (r_owner == IDX_W'(NUM_REQ - 1)) ? '0 : r_owner + IDX_W'(1);

  always_ff @(posedge mvmt_clk or posedge reset) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_rr_ptr    <= '0;
      r_owner     <= '0;
      r_we        <= 1'b0;
      r_wait_cnt  <= '0;
      r_gnt       <= '0;
      r_ack       <= '0;
      r_rdata     <= '0;
      r_bram_en   <= 1'b0;
      r_bram_we   <= 1'b0;
      r_bram_addr <= '0;
      r_bram_din  <= '0;
      r_busy      <= 1'b0;
    end else begin
      r_ack <= '0;
      case (r_state)
        ST_IDLE: begin
          if (i_en && w_pick_valid) begin
            r_owner     <= w_pick_idx;
            r_gnt       <= w_pick_onehot;
            r_we        <= w_sel_we;
            r_bram_en   <= 1'b1;
            r_bram_we   <= w_sel_we;
            r_bram_addr <= w_sel_addr;
            r_bram_din  <= w_sel_din;
            r_busy      <= 1'b1;
            r_state     <= ST_ACCESS;
          end
        end
        ST_ACCESS: begin
          r_bram_en  <= 1'b0;
          r_bram_we  <= 1'b0;
          r_wait_cnt <= '0;
          r_state    <= ST_WAIT;
        end
        ST_WAIT: begin
          if (r_wait_cnt == LAST_WAIT) begin
            if (!r_we) begin
              r_rdata <= i_bram_dout;
            end
            r_state <= ST_DONE;
          end else begin
            r_wait_cnt <= r_wait_cnt + 2'd1;
          end
        end
        ST_DONE: begin
          // ack lands in the following IDLE cycle so the owner can drop req before it is sampled again
          r_ack    <= r_gnt;
          r_gnt    <= '0;
          r_rr_ptr <= w_next_ptr;
          r_busy   <= 1'b0;
          r_state  <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign s_req.gnt   = r_gnt;
  assign s_req.ack   = r_ack;
  assign s_req.rdata = r_rdata;
  assign o_bram_en   = r_bram_en;
  assign o_bram_we   = r_bram_we;
  assign o_bram_addr = r_bram_addr;
  assign o_bram_din  = r_bram_din;
  assign o_busy      = r_busy;

endmodule

// File: tb/tb_maze_bram_arbiter.sv
// tb/tb_maze_bram_arbiter.sv - scoreboard bench for maze_bram_arbiter at BRAM_LAT 1 and 3
module tb_maze_bram_arbiter;
  import maze_bram_arbiter_pkg::*;

  localparam int NR = 4;
  localparam int AW = 8;
  localparam int DW = 9;
  localparam logic [DW-1:0] POISON = 9'h155;

  typedef struct {
    int          idx;
    bit          we;
    logic [DW-1:0] rdata;
  } exp_t;

  logic mvmt_clk = 1'b0;
  logic reset    = 1'b1;
  logic en       = 1'b0;
  logic mem_init = 1'b1;

  always #5 mvmt_clk = ~mvmt_clk;

  maze_bram_arbiter_if #(.NUM_REQ(NR), .ADDR_W(AW), .DATA_W(DW)) rq1 ();
  maze_bram_arbiter_if #(.NUM_REQ(NR), .ADDR_W(AW), .DATA_W(DW)) rq3 ();

  logic          bram_en1, bram_we1, busy1;
  logic [AW-1:0] bram_addr1;
  logic [DW-1:0] bram_din1, bram_dout1;
  logic          bram_en3, bram_we3, busy3;
  logic [AW-1:0] bram_addr3;
  logic [DW-1:0] bram_din3, bram_dout3;

  maze_bram_arbiter #(.NUM_REQ(NR), .ADDR_W(AW), .DATA_W(DW), .BRAM_LAT(1)) u_dut1 (
    .mvmt_clk (mvmt_clk), .reset (reset), .i_en (en), .s_req (rq1),
    .o_bram_en (bram_en1), .o_bram_we (bram_we1), .o_bram_addr (bram_addr1),
    .o_bram_din (bram_din1), .i_bram_dout (bram_dout1), .o_busy (busy1)
  );

  maze_bram_arbiter #(.NUM_REQ(NR), .ADDR_W(AW), .DATA_W(DW), .BRAM_LAT(3)) u_dut3 (
    .mvmt_clk (mvmt_clk), .reset (reset), .i_en (en), .s_req (rq3),
    .o_bram_en (bram_en3), .o_bram_we (bram_we3), .o_bram_addr (bram_addr3),
    .o_bram_din (bram_din3), .i_bram_dout (bram_dout3), .o_busy (busy3)
  );

  function automatic logic [DW-1:0] init_val(input int a);
    logic [DW-1:0] v;
    v = '0;
    v[CELL_WALL_BIT] = (a % 3 == 0);
    v[CELL_COLL_MSB:CELL_COLL_LSB] = 3'(a % 5);
    if (a == int'(cell_addr(4'd3, 4'd2))) v = {5'b0, COLL_GEM, 1'b1};
    return v;
  endfunction

  // BRAM models: dout is poisoned unless it follows a real read, so mistimed captures show up
  logic [DW-1:0] mem1 [256];
  logic [DW-1:0] mem3 [256];
  logic [DW-1:0] pipe1;
  logic [DW-1:0] pipe3 [3];

  always @(posedge mvmt_clk) begin
    if (mem_init) begin
      for (int a = 0; a < 256; a++) mem1[a] <= init_val(a);
    end else if (bram_en1 && bram_we1) begin
      mem1[bram_addr1] <= bram_din1;
    end
    pipe1 <= (bram_en1 && !bram_we1) ? mem1[bram_addr1] : POISON;
  end
  assign bram_dout1 = pipe1;

  always @(posedge mvmt_clk) begin
    if (mem_init) begin
      for (int a = 0; a < 256; a++) mem3[a] <= init_val(a);
    end else if (bram_en3 && bram_we3) begin
      mem3[bram_addr3] <= bram_din3;
    end
    pipe3[0] <= (bram_en3 && !bram_we3) ? mem3[bram_addr3] : POISON;
    pipe3[1] <= pipe3[0];
    pipe3[2] <= pipe3[1];
  end
  assign bram_dout3 = pipe3[2];

  int n_tests = 0;
  int n_fail  = 0;
  exp_t q1[$];
  exp_t q3[$];
  logic [DW-1:0] model1 [256];
  logic [DW-1:0] model3 [256];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic post1(input int idx, input bit we, input logic [AW-1:0] addr, input logic [DW-1:0] din);
    rq1.req_we[idx]             = we;
    rq1.req_addr[idx*AW +: AW]  = addr;
    rq1.req_din[idx*DW +: DW]   = din;
    rq1.req[idx]                = 1'b1;
  endtask

  task automatic post3(input int idx, input bit we, input logic [AW-1:0] addr, input logic [DW-1:0] din);
    rq3.req_we[idx]             = we;
    rq3.req_addr[idx*AW +: AW]  = addr;
    rq3.req_din[idx*DW +: DW]   = din;
    rq3.req[idx]                = 1'b1;
  endtask

  task automatic expect1(input int idx, input bit we, input logic [AW-1:0] addr, input logic [DW-1:0] din);
    exp_t e;
    e.idx   = idx;
    e.we    = we;
    e.rdata = we ? '0 : model1[addr];
    if (we) model1[addr] = din;
    q1.push_back(e);
  endtask

  task automatic expect3(input int idx, input bit we, input logic [AW-1:0] addr, input logic [DW-1:0] din);
    exp_t e;
    e.idx   = idx;
    e.we    = we;
    e.rdata = we ? '0 : model3[addr];
    if (we) model3[addr] = din;
    q3.push_back(e);
  endtask

  task automatic drain1(input int n, input bit hold, input int budget);
    int seen;
    int cyc;
    seen = 0;
    cyc  = 0;
    while (seen < n && cyc < budget) begin
      @(negedge mvmt_clk);
      cyc++;
      if (rq1.ack != '0) begin
        seen++;
        if (!hold) rq1.req = rq1.req & ~rq1.ack;
        else if (seen == n) rq1.req = '0;
      end
    end
    chk("drain1_acks", seen, n);
  endtask

  always @(negedge mvmt_clk) begin : mon1
    exp_t e;
    if (!reset && rq1.ack != '0) begin
      if (q1.size() == 0) begin
        chk("spurious_ack1", 32'(rq1.ack), 0);
      end else begin
        e = q1.pop_front();
        chk("ack_owner1", 32'(rq1.ack), 32'(1) << e.idx);
        chk("gnt_clear1", 32'(rq1.gnt), 0);
        if (!e.we) chk("rdata1", 32'(rq1.rdata), 32'(e.rdata));
      end
    end
  end

  always @(negedge mvmt_clk) begin : mon3
    exp_t e;
    if (!reset && rq3.ack != '0) begin
      if (q3.size() == 0) begin
        chk("spurious_ack3", 32'(rq3.ack), 0);
      end else begin
        e = q3.pop_front();
        chk("ack_owner3", 32'(rq3.ack), 32'(1) << e.idx);
        if (!e.we) chk("rdata3", 32'(rq3.rdata), 32'(e.rdata));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int cyc;
    int ben;
    int ri;
    bit we_b;
    logic [AW-1:0] a;
    logic [DW-1:0] d;

    rq1.req = '0; rq1.req_we = '0; rq1.req_addr = '0; rq1.req_din = '0;
    rq3.req = '0; rq3.req_we = '0; rq3.req_addr = '0; rq3.req_din = '0;
    for (int i = 0; i < 256; i++) begin
      model1[i] = init_val(i);
      model3[i] = init_val(i);
    end
    repeat (3) @(negedge mvmt_clk);
    chk("rst_gnt", 32'(rq1.gnt), 0);
    chk("rst_ack", 32'(rq1.ack), 0);
    chk("rst_busy", 32'(busy1), 0);
    chk("rst_bram_en", 32'(bram_en1), 0);
    chk("rst_rdata", 32'(rq1.rdata), 0);
    mem_init = 1'b0;
    reset    = 1'b0;
    en       = 1'b1;
    @(negedge mvmt_clk);

    // single read by the player
    post1(0, 1'b0, 8'h23, '0);
    expect1(0, 1'b0, 8'h23, '0);
    cyc = 0;
    ben = 0;
    while (rq1.ack == '0 && cyc < 20) begin
      @(negedge mvmt_clk);
      cyc++;
      if (bram_en1) ben++;
      if (cyc == 1) begin
        chk("t1_gnt", 32'(rq1.gnt), 32'h1);
        chk("t1_busy", 32'(busy1), 1);
        chk("t1_bram_addr", 32'(bram_addr1), 32'h23);
      end
    end
    chk("t1_latency", cyc, 4);
    chk("t1_bram_en_cycles", ben, 1);
    chk("t1_rdata", 32'(rq1.rdata), 32'h005);
    rq1.req[0] = 1'b0;

    // write by 1 and read by 2 posted together; pointer sits at 1
    @(negedge mvmt_clk);
    post1(1, 1'b1, 8'h23, 9'h001);
    post1(2, 1'b0, 8'h23, '0);
    expect1(1, 1'b1, 8'h23, 9'h001);
    expect1(2, 1'b0, 8'h23, '0);
    drain1(2, 1'b0, 60);
    chk("t2_rdata", 32'(rq1.rdata), 32'h001);

    // enable low blocks grants; dropping it during WAIT does not abort
    @(negedge mvmt_clk);
    en = 1'b0;
    post1(3, 1'b0, 8'h40, '0);
    repeat (8) @(negedge mvmt_clk);
    chk("t4_gnt_en0", 32'(rq1.gnt), 0);
    chk("t4_busy_en0", 32'(busy1), 0);
    expect1(3, 1'b0, 8'h40, '0);
    en  = 1'b1;
    cyc = 0;
    while (rq1.gnt == '0 && cyc < 10) begin
      @(negedge mvmt_clk);
      cyc++;
    end
    chk("t4_gnt", 32'(rq1.gnt), 32'h8);
    @(negedge mvmt_clk);
    en = 1'b0;
    drain1(1, 1'b0, 60);
    @(negedge mvmt_clk);
    en = 1'b1;

    // all four held for eight transactions; pointer sits at 0
    for (int i = 0; i < NR; i++) post1(i, 1'b0, AW'(8'h10 + i), '0);
    for (int n = 0; n < 8; n++) expect1(n % NR, 1'b0, AW'(8'h10 + (n % NR)), '0);
    drain1(8, 1'b1, 200);

    // reset lands in WAIT
    @(negedge mvmt_clk);
    post1(1, 1'b0, 8'h50, '0);
    cyc = 0;
    while (rq1.gnt == '0 && cyc < 10) begin
      @(negedge mvmt_clk);
      cyc++;
    end
    chk("t5_gnt_before", 32'(rq1.gnt), 32'h2);
    @(negedge mvmt_clk);
    reset = 1'b1;
    #1;
    chk("t5_gnt", 32'(rq1.gnt), 0);
    chk("t5_ack", 32'(rq1.ack), 0);
    chk("t5_busy", 32'(busy1), 0);
    chk("t5_bram_en", 32'(bram_en1), 0);
    rq1.req[1] = 1'b0;
    @(negedge mvmt_clk);
    reset = 1'b0;
    @(negedge mvmt_clk);
    post1(2, 1'b0, 8'h51, '0);
    expect1(2, 1'b0, 8'h51, '0);
    cyc = 0;
    while (rq1.gnt == '0 && cyc < 10) begin
      @(negedge mvmt_clk);
      cyc++;
    end
    chk("t5_gnt_after", 32'(rq1.gnt), 32'h4);
    drain1(1, 1'b0, 60);

    // BRAM_LAT=3 instance: mixed reads and writes over a few cells
    for (int t = 0; t < 12; t++) begin
      ri   = t % NR;
      we_b = (t % 3 == 0);
      a    = AW'(8'h60 + $urandom_range(0, 3));
      d    = DW'($urandom_range(0, 255));
      @(negedge mvmt_clk);
      post3(ri, we_b, a, d);
      expect3(ri, we_b, a, d);
      cyc = 0;
      while (rq3.ack == '0 && cyc < 30) begin
        @(negedge mvmt_clk);
        cyc++;
      end
      chk("t6_latency", cyc, 6);
      rq3.req[ri] = 1'b0;
    end

    repeat (3) @(negedge mvmt_clk);
    chk("q1_empty", q1.size(), 0);
    chk("q3_empty", q3.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
